forwarding_stall_unit: RTL and testbench

- Next-generation EX-stage operand forwarding block for the pipelined MIPS core.
- Generates the forwarding select codes for both ALU operands from register indices instead of taking them as inputs, and muxes the operand data.
- Adds a load-use stall FSM with a parametrised stall length.
- Adds operand hold registers so that forwarded values survive a pipeline freeze, for example a debug-unit step, while MEM/WB retires.

---
 rtl/forwarding_stall_unit.sv | 150 +++++++++++++++
 tb/tb_forwarding_stall_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/forwarding_stall_unit.sv
// EX-stage operand forwarding with freeze hold registers and a load-use stall FSM.
// Select codes: 000 ID/EX, 001 EX/MEM, 010 MEM/WB, 100 hold register.
module forwarding_stall_unit #(
    parameter int BITS_SIZE          = 32,
    parameter int BITS_REG           = 5,
    parameter int BITS_CORTOCIRCUITO = 3,
    parameter int LOAD_STALL_CYCLES  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_freeze,
    input  logic [BITS_REG-1:0]           i_ifid_rs,
    input  logic [BITS_REG-1:0]           i_ifid_rt,
    input  logic [BITS_REG-1:0]           i_idex_rs,
    input  logic [BITS_REG-1:0]           i_idex_rt,
    input  logic                          i_idex_memread,
    input  logic [BITS_SIZE-1:0]          i_idex_register1,
    input  logic [BITS_SIZE-1:0]          i_idex_register2,
    input  logic [BITS_REG-1:0]           i_exmem_rd,
    input  logic                          i_exmem_regwrite,
    input  logic [BITS_SIZE-1:0]          i_exmem_register,
    input  logic [BITS_REG-1:0]           i_memwb_rd,
    input  logic                          i_memwb_regwrite,
    input  logic [BITS_SIZE-1:0]          i_memwb_register,
    output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_A,
    output logic [BITS_CORTOCIRCUITO-1:0] o_corto_register_B,
    output logic [BITS_SIZE-1:0]          o_mux_alu_a,
    output logic [BITS_SIZE-1:0]          o_mux_alu_b,
    output logic                          o_stall
);

    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_IDEX  = BITS_CORTOCIRCUITO'(0);
    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_EXMEM = BITS_CORTOCIRCUITO'(1);
    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_MEMWB = BITS_CORTOCIRCUITO'(2);
    localparam logic [BITS_CORTOCIRCUITO-1:0] SEL_HOLD  = BITS_CORTOCIRCUITO'(4);
    localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL_CYCLES - 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [BITS_SIZE-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic                   hold_valid_q, hold_valid_d;
    logic                   freeze_d_q, freeze_d_d;

    logic [BITS_CORTOCIRCUITO-1:0] norm_sel_a, norm_sel_b;
    logic [BITS_SIZE-1:0]          norm_a, norm_b;
    logic                          exmem_fwd_a, exmem_fwd_b, memwb_fwd_a, memwb_fwd_b;
    logic                          use_hold, hazard;

    // Normal forwarding select: EX/MEM beats MEM/WB, register 0 never forwarded
    always_comb begin
        exmem_fwd_a = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_idex_rs);
        exmem_fwd_b = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_idex_rt);
        memwb_fwd_a = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_idex_rs);
        memwb_fwd_b = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_idex_rt);
        norm_sel_a  = SEL_IDEX;
        norm_a      = i_idex_register1;
        norm_sel_b  = SEL_IDEX;
        norm_b      = i_idex_register2;
        if (exmem_fwd_a) begin
            norm_sel_a = SEL_EXMEM;
            norm_a     = i_exmem_register;
        end else if (memwb_fwd_a) begin
            norm_sel_a = SEL_MEMWB;
            norm_a     = i_memwb_register;
        end
        if (exmem_fwd_b) begin
            norm_sel_b = SEL_EXMEM;
            norm_b     = i_exmem_register;
        end else if (memwb_fwd_b) begin
            norm_sel_b = SEL_MEMWB;
            norm_b     = i_memwb_register;
        end
    end

    // Output mux: held operands only once the capture edge has passed
    always_comb begin
        use_hold           = i_freeze && hold_valid_q;
        o_corto_register_A = use_hold ? SEL_HOLD : norm_sel_a;
        o_corto_register_B = use_hold ? SEL_HOLD : norm_sel_b;
        o_mux_alu_a        = use_hold ? hold_a_q : norm_a;
        o_mux_alu_b        = use_hold ? hold_b_q : norm_b;
    end

    // Hold register capture on the first freeze cycle, released when unfrozen
    always_comb begin
        freeze_d_d   = i_freeze;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        hold_valid_d = hold_valid_q;
        if (i_freeze && !freeze_d_q) begin
            hold_a_d     = norm_a;
            hold_b_d     = norm_b;
            hold_valid_d = 1'b1;
        end else if (!i_freeze) begin
            hold_valid_d = 1'b0;
        end
    end

    // Load-use stall FSM; frozen cycles neither count down nor detect hazards
    always_comb begin
        hazard  = i_idex_memread && (i_idex_rt != '0) &&
                  ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
        state_d = state_q;
        cnt_d   = cnt_q;
        o_stall = 1'b0;
        case (state_q)
            IDLE: begin
                o_stall = hazard && !i_freeze;
                if (o_stall && (LOAD_STALL_CYCLES > 1)) begin
                    state_d = STALL;
                    cnt_d   = STALL_LOAD;
                end
            end
            STALL: begin
                o_stall = 1'b1;
                if (!i_freeze) begin
                    if (cnt_q == 2'd1) begin
                        state_d = IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            hold_valid_q <= 1'b0;
            freeze_d_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            hold_valid_q <= hold_valid_d;
            freeze_d_q   <= freeze_d_d;
        end
    end

endmodule

// File: tb/tb_forwarding_stall_unit.sv
// Scoreboard bench: two instances (1 and 3 stall cycles) share stimulus;
// expected outputs are queued per cycle and checked at the falling edge.
module tb_forwarding_stall_unit;

    logic        clk = 1'b0;
    logic        rst, frz;
    logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic        memread, exmem_rw, memwb_rw;
    logic [31:0] reg1, reg2, exmem_d, memwb_d;

    logic [2:0]  ca1, cb1, ca3, cb3;
    logic [31:0] a1, b1, a3, b3;
    logic        st1, st3;

    typedef struct {
        string       name;
        logic [2:0]  ca;
        logic [31:0] da;
        logic [2:0]  cb;
        logic [31:0] db;
        logic        s1;
        logic        s3;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    int   cycles = 0;

    always #5 clk = ~clk;

    forwarding_stall_unit #(.LOAD_STALL_CYCLES(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_freeze(frz),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
        .i_idex_rs(idex_rs), .i_idex_rt(idex_rt), .i_idex_memread(memread),
        .i_idex_register1(reg1), .i_idex_register2(reg2),
        .i_exmem_rd(exmem_rd), .i_exmem_regwrite(exmem_rw), .i_exmem_register(exmem_d),
        .i_memwb_rd(memwb_rd), .i_memwb_regwrite(memwb_rw), .i_memwb_register(memwb_d),
        .o_corto_register_A(ca1), .o_corto_register_B(cb1),
        .o_mux_alu_a(a1), .o_mux_alu_b(b1), .o_stall(st1)
    );

    forwarding_stall_unit #(.LOAD_STALL_CYCLES(3)) u3 (
        .i_clk(clk), .i_reset(rst), .i_freeze(frz),
        .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
        .i_idex_rs(idex_rs), .i_idex_rt(idex_rt), .i_idex_memread(memread),
        .i_idex_register1(reg1), .i_idex_register2(reg2),
        .i_exmem_rd(exmem_rd), .i_exmem_regwrite(exmem_rw), .i_exmem_register(exmem_d),
        .i_memwb_rd(memwb_rd), .i_memwb_regwrite(memwb_rw), .i_memwb_register(memwb_d),
        .o_corto_register_A(ca3), .o_corto_register_B(cb3),
        .o_mux_alu_a(a3), .o_mux_alu_b(b3), .o_stall(st3)
    );

    task automatic clr();
        rst = 1'b0; frz = 1'b0;
        ifid_rs = '0; ifid_rt = '0; idex_rs = '0; idex_rt = '0; memread = 1'b0;
        reg1 = 32'h1111_1111; reg2 = 32'h2222_2222;
        exmem_rd = '0; exmem_rw = 1'b0; exmem_d = 32'h0;
        memwb_rd = '0; memwb_rw = 1'b0; memwb_d = 32'h0;
    endtask

    // Queue this cycle's expectation, then advance to just after the next edge
    task automatic cyc(input string n, input logic [2:0] ca, input logic [31:0] da,
                       input logic [2:0] cb, input logic [31:0] db,
                       input logic s1, input logic s3);
        exp_t e;
        e.name = n; e.ca = ca; e.da = da; e.cb = cb; e.db = db; e.s1 = s1; e.s3 = s3;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: pop and compare one expectation per cycle; also the run watchdog
    always @(negedge clk) begin
        cycles++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, " codeA u1"}, 32'(ca1), 32'(e.ca));
            chk({e.name, " dataA u1"}, a1, e.da);
            chk({e.name, " codeB u1"}, 32'(cb1), 32'(e.cb));
            chk({e.name, " dataB u1"}, b1, e.db);
            chk({e.name, " codeA u3"}, 32'(ca3), 32'(e.ca));
            chk({e.name, " dataA u3"}, a3, e.da);
            chk({e.name, " codeB u3"}, 32'(cb3), 32'(e.cb));
            chk({e.name, " dataB u3"}, b3, e.db);
            chk({e.name, " stall u1"}, 32'(st1), 32'(e.s1));
            chk({e.name, " stall u3"}, 32'(st3), 32'(e.s3));
        end else if (done) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        if (cycles > 2000) begin
            errors++;
            $display("FAIL watchdog: got %0d cycles expected completion", cycles);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    localparam logic [31:0] R1 = 32'h1111_1111;
    localparam logic [31:0] R2 = 32'h2222_2222;

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        clr();                                     cyc("reset",    3'b000, R1, 3'b000, R2, 0, 0);
        clr(); idex_rs = 5; exmem_rd = 5; exmem_rw = 1; exmem_d = 32'hAAAA_0001;
               memwb_rd = 5; memwb_rw = 1; memwb_d = 32'hBBBB_0002;
                                                   cyc("prio",     3'b001, 32'hAAAA_0001, 3'b000, R2, 0, 0);
        exmem_rw = 0;                              cyc("memwb",    3'b010, 32'hBBBB_0002, 3'b000, R2, 0, 0);
        clr(); exmem_rd = 0; exmem_rw = 1; exmem_d = 32'hFFFF_FFFF; reg2 = 32'h1234_5678;
                                                   cyc("reg0",     3'b000, R1, 3'b000, 32'h1234_5678, 0, 0);
        clr(); idex_rt = 7; memwb_rd = 7; memwb_rw = 1; memwb_d = 32'h7777_0007;
                                                   cyc("fwdB",     3'b000, R1, 3'b010, 32'h7777_0007, 0, 0);

        // load-use hazard, freeze held for two cycles inside the 3-cycle stall
        clr(); memread = 1; idex_rt = 8; ifid_rt = 8;
                                                   cyc("lu0",      3'b000, R1, 3'b000, R2, 1, 1);
        clr();                                     cyc("lu1",      3'b000, R1, 3'b000, R2, 0, 1);
        clr(); frz = 1;                            cyc("luF0",     3'b000, R1, 3'b000, R2, 0, 1);
        clr(); frz = 1;                            cyc("luF1",     3'b100, R1, 3'b100, R2, 0, 1);
        clr();                                     cyc("lu2",      3'b000, R1, 3'b000, R2, 0, 1);
        clr();                                     cyc("luEnd",    3'b000, R1, 3'b000, R2, 0, 0);

        // freeze hold of an EX/MEM forward
        clr(); idex_rs = 3; exmem_rd = 3; exmem_rw = 1; exmem_d = 32'hCAFE_0000; frz = 1;
                                                   cyc("frz0",     3'b001, 32'hCAFE_0000, 3'b000, R2, 0, 0);
        exmem_d = 32'hDEAD_0000;                   cyc("frz1",     3'b100, 32'hCAFE_0000, 3'b100, R2, 0, 0);
                                                   cyc("frz2",     3'b100, 32'hCAFE_0000, 3'b100, R2, 0, 0);
        frz = 0;                                   cyc("frzRel",   3'b001, 32'hDEAD_0000, 3'b000, R2, 0, 0);

        // reset in the second stall cycle while hold is valid
        clr(); memread = 1; idex_rt = 9; ifid_rs = 9;
                                                   cyc("rs0",      3'b000, R1, 3'b000, R2, 1, 1);
        clr(); frz = 1; idex_rs = 4; memwb_rd = 4; memwb_rw = 1; memwb_d = 32'h4444_0004;
                                                   cyc("rs1",      3'b010, 32'h4444_0004, 3'b000, R2, 0, 1);
        frz = 0; rst = 1;                          cyc("rs2",      3'b010, 32'h4444_0004, 3'b000, R2, 0, 1);
        clr(); frz = 1; idex_rs = 4; exmem_rd = 4; exmem_rw = 1; exmem_d = 32'h5555_0005;
                                                   cyc("postRst",  3'b001, 32'h5555_0005, 3'b000, R2, 0, 0);
        exmem_d = 32'h6666_0006;                   cyc("postHold", 3'b100, 32'h5555_0005, 3'b100, R2, 0, 0);
        clr();                                     cyc("postRel",  3'b000, R1, 3'b000, R2, 0, 0);

        // hazard ignored while frozen, detected once released
        clr(); frz = 1; memread = 1; idex_rt = 6; ifid_rt = 6;
                                                   cyc("hzFrz",    3'b000, R1, 3'b000, R2, 0, 0);
        frz = 0;                                   cyc("hzGo",     3'b000, R1, 3'b000, R2, 1, 1);
        clr();                                     cyc("hz1",      3'b000, R1, 3'b000, R2, 0, 1);
                                                   cyc("hz2",      3'b000, R1, 3'b000, R2, 0, 1);
                                                   cyc("hz3",      3'b000, R1, 3'b000, R2, 0, 0);

        done = 1'b1;
    end

endmodule
